// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared state encodings and widths for the reaction game controller
// Purpose: state enum and width constants common to the reaction game RTL.
// Ports: none (package).

package reaction_pkg;

  localparam int MODE_W = 2;
  localparam int ST_W   = 3;

  typedef enum logic [ST_W-1:0] {
    ST_SETUP = 3'd0,
    ST_ARM   = 3'd1,
    ST_COUNT = 3'd2,
    ST_SCORE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/reaction_round_ctrl_btn_press.sv
// rtl/reaction_round_ctrl_btn_press.sv - tick-gated rising-edge press detector for one button
// Purpose: turns a raw button level into a one-cycle press pulse, sampling only on tick_en_i.
// Ports:
//   clk        in  system clock
//   rst        in  synchronous active-low reset
//   tick_en_i  in  sampling strobe
//   btn_i      in  raw button level
//   press_o    out high on a tick where the button is sampled 1 after a sampled 0

module btn_press (
  input  logic clk,
  input  logic rst,
  input  logic tick_en_i,
  input  logic btn_i,
  output logic press_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= 1'b0;
    end else if (tick_en_i) begin
      prev_q <= btn_i;
    end
  end

  // Combinational so the press acts on the same tick it is sampled.
  assign press_o = tick_en_i & btn_i & ~prev_q;

endmodule

// File: rtl/reaction_round_ctrl.sv
// rtl/reaction_round_ctrl.sv - multi-round reaction game controller
// Purpose: per round latches a random target, counts up at a mode-dependent rate until
//   the player stops it, then scores the stop error on an LED bar; accumulates total and
//   best error across ROUNDS rounds.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   tick_en             20 Hz button sampling strobe
//   btn_up/down/sel     raw buttons
//   rand_in             free-running random value
//   state, mode         FSM state, difficulty
//   number, round_idx   display value, 0-based round
//   total_err, best_err accumulated and best error
//   led, done           score bar, game-over flag

module reaction_round_ctrl
  import reaction_pkg::*;
#(
  parameter int                      NUM_W       = 14,
  parameter int                      LED_W       = 16,
  parameter int                      NUM_MODES   = 3,
  parameter logic [20*NUM_MODES-1:0] MODE_TICKS  = {20'd100000, 20'd200000, 20'd1000000},
  parameter int                      MODE_RST    = 1,
  parameter int                      ERR_PER_LED = 30,
  parameter int                      ROUNDS      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_en,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_sel,
  input  logic [NUM_W-1:0]   rand_in,
  output logic [ST_W-1:0]    state,
  output logic [MODE_W-1:0]  mode,
  output logic [NUM_W-1:0]   number,
  output logic [3:0]         round_idx,
  output logic [NUM_W+3:0]   total_err,
  output logic [NUM_W-1:0]   best_err,
  output logic [LED_W-1:0]   led,
  output logic               done
);

  localparam int                TICK_W     = 20;
  localparam logic [MODE_W-1:0] MODE_MAX   = MODE_W'(NUM_MODES - 1);
  localparam logic [3:0]        LAST_ROUND = 4'(ROUNDS - 1);

  logic up_p, dn_p, sel_p;

  btn_press u_up  (.clk(clk), .rst(rst), .tick_en_i(tick_en), .btn_i(btn_up),   .press_o(up_p));
  btn_press u_dn  (.clk(clk), .rst(rst), .tick_en_i(tick_en), .btn_i(btn_down), .press_o(dn_p));
  btn_press u_sel (.clk(clk), .rst(rst), .tick_en_i(tick_en), .btn_i(btn_sel),  .press_o(sel_p));

  state_e              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [NUM_W-1:0]    number_q, number_d;
  logic [NUM_W-1:0]    target_q, target_d;
  logic [TICK_W-1:0]   cnt_q, cnt_d;
  logic [3:0]          round_q, round_d;
  logic [NUM_W+3:0]    total_q, total_d;
  logic [NUM_W-1:0]    best_q, best_d;
  logic [NUM_W-1:0]    err_q, err_d;
  logic [LED_W-1:0]    led_q, led_d;

  logic [TICK_W-1:0]   tick_lim;
  logic [NUM_W-1:0]    target_new;
  logic [NUM_W-1:0]    err_abs;
  logic [NUM_W+4:0]    sum;
  logic [NUM_W-1:0]    quot;
  logic [LED_W-1:0]    led_bar;

  always_comb begin
    tick_lim   = MODE_TICKS[int'(mode_q)*TICK_W +: TICK_W];
    // A zero target would make a perfect stop impossible to distinguish from "never started".
    target_new = (rand_in == '0) ? NUM_W'(1) : rand_in;
    err_abs    = (number_q >= target_q) ? (number_q - target_q) : (target_q - number_q);
    sum        = {1'b0, total_q} + {5'b0, err_abs};
    quot       = err_q / NUM_W'(ERR_PER_LED);
    // LED i stays lit while fewer than i+1 LEDs are extinguished; this also covers the
    // fully-dark case without a variable shift past LED_W.
    for (int i = 0; i < LED_W; i++) begin
      led_bar[i] = (quot <= NUM_W'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    number_d = number_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    round_d  = round_q;
    total_d  = total_q;
    best_d   = best_q;
    err_d    = err_q;
    led_d    = led_q;
    unique case (state_q)
      ST_SETUP: begin
        if (sel_p) begin
          state_d  = ST_ARM;
          target_d = target_new;
        end else if (up_p && !dn_p) begin
          if (mode_q < MODE_MAX) mode_d = mode_q + 1'b1;
        end else if (dn_p && !up_p) begin
          if (mode_q != '0) mode_d = mode_q - 1'b1;
        end
      end
      ST_ARM: begin
        number_d = target_q;
        if (sel_p) begin
          state_d  = ST_COUNT;
          number_d = '0;
          cnt_d    = '0;
        end
      end
      ST_COUNT: begin
        if (sel_p) begin
          state_d = ST_SCORE;
          err_d   = err_abs;
          total_d = sum[NUM_W+4] ? '1 : sum[NUM_W+3:0];
          if (err_abs < best_q) best_d = err_abs;
        end else if (cnt_q == tick_lim - 1'b1) begin
          cnt_d = '0;
          if (number_q != '1) number_d = number_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SCORE: begin
        led_d = led_bar;
        if (sel_p) begin
          if (round_q < LAST_ROUND) begin
            state_d  = ST_ARM;
            round_d  = round_q + 1'b1;
            target_d = target_new;
          end else begin
            state_d  = ST_DONE;
            number_d = total_q[NUM_W-1:0];
          end
        end
      end
      ST_DONE: begin
        number_d = total_q[NUM_W-1:0];
        if (sel_p) begin
          state_d = ST_SETUP;
          round_d = '0;
          total_d = '0;
          best_d  = '1;
          led_d   = '0;
        end
      end
      default: state_d = ST_SETUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_SETUP;
      mode_q   <= MODE_W'(MODE_RST);
      number_q <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      round_q  <= '0;
      total_q  <= '0;
      best_q   <= '1;
      err_q    <= '0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      number_q <= number_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      round_q  <= round_d;
      total_q  <= total_d;
      best_q   <= best_d;
      err_q    <= err_d;
      led_q    <= led_d;
    end
  end

  assign state     = state_q;
  assign mode      = mode_q;
  assign number    = number_q;
  assign round_idx = round_q;
  assign total_err = total_q;
  assign best_err  = best_q;
  assign led       = led_q;
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// tb/tb_reaction_round_ctrl.sv - self-checking bench for reaction_round_ctrl

module tb_reaction_round_ctrl;

  logic        clk = 1'b0;
  logic        rst, tick_en, btn_up, btn_down, btn_sel;
  logic [13:0] rand_in;
  logic [2:0]  state;
  logic [1:0]  mode;
  logic [13:0] number;
  logic [3:0]  round_idx;
  logic [17:0] total_err;
  logic [13:0] best_err;
  logic [15:0] led;
  logic        done;

  always #5 clk = ~clk;

  reaction_round_ctrl #(
    .MODE_TICKS({20'd4, 20'd2, 20'd1}),
    .ROUNDS(2)
  ) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .btn_up(btn_up), .btn_down(btn_down),
    .btn_sel(btn_sel), .rand_in(rand_in), .state(state), .mode(mode), .number(number),
    .round_idx(round_idx), .total_err(total_err), .best_err(best_err), .led(led), .done(done)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc = 0;
  int last_edge = 0;
  int m_mode, m_total, m_best;

  function automatic int ticks_of(input int m);
    return (m == 0) ? 1 : (m == 1) ? 2 : 4;
  endfunction

  function automatic logic [15:0] bar_of(input int err);
    logic [15:0] full;
    int off;
    full = 16'hFFFF;
    off = err / 30;
    if (off >= 16) return 16'h0000;
    return full << off;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick(input logic u, input logic d, input logic s);
    btn_up = u; btn_down = d; btn_sel = s; tick_en = 1'b1;
    step();
    tick_en = 1'b0;
  endtask

  task automatic press(input logic u, input logic d, input logic s);
    tick(u, d, s);
    last_edge = cyc;
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0; tick_en = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    step();
    rst = 1'b1;
    m_mode = 1; m_total = 0; m_best = 16383;
  endtask

  task automatic model_mode(input logic u, input logic d);
    if (u && !d && m_mode < 2) m_mode++;
    else if (d && !u && m_mode > 0) m_mode--;
  endtask

  // Enters ARM with target t, starts counting, stops after run clocks of counting.
  task automatic play_round(input int t, input int run, output int exp_num);
    int e, n;
    rand_in = 14'(t);
    press(1'b0, 1'b0, 1'b1);
    idle(1);
    press(1'b0, 1'b0, 1'b1);
    e = last_edge;
    idle(e + run - cyc);
    press(1'b0, 1'b0, 1'b1);
    n = run / ticks_of(m_mode);
    exp_num = (n > 16383) ? 16383 : n;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
    vectors++; if (mode !== 2'd1) begin errors++; $display("FAIL rst_mode got %0d exp 1", mode); end
    vectors++; if (number !== 14'd0) begin errors++; $display("FAIL rst_number got %0d exp 0", number); end
    vectors++; if (round_idx !== 4'd0) begin errors++; $display("FAIL rst_round got %0d exp 0", round_idx); end
    vectors++; if (total_err !== 18'd0) begin errors++; $display("FAIL rst_total got %0d exp 0", total_err); end
    vectors++; if (best_err !== 14'h3FFF) begin errors++; $display("FAIL rst_best got %0h exp 3fff", best_err); end
    vectors++; if (led !== 16'h0) begin errors++; $display("FAIL rst_led got %0h exp 0", led); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0d exp 0", done); end
  endtask

  task automatic test_mode_select();
    for (int i = 0; i < 7; i++) begin
      press(i < 2, i >= 2, 1'b0);
      model_mode(i < 2, i >= 2);
      vectors++; if (mode !== 2'(m_mode)) begin errors++; $display("FAIL mode_seq[%0d] got %0d exp %0d", i, mode, m_mode); end
    end
    press(1'b1, 1'b0, 1'b0); model_mode(1'b1, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    vectors++; if (mode !== 2'd1) begin errors++; $display("FAIL mode_up_down got %0d exp 1", mode); end
    press(1'b0, 1'b1, 1'b0); model_mode(1'b0, 1'b1);
    vectors++; if (mode !== 2'(m_mode)) begin errors++; $display("FAIL mode_down got %0d exp %0d", mode, m_mode); end
    vectors++; if (state !== 3'd0) begin errors++; $display("FAIL mode_state got %0d exp 0", state); end
  endtask

  task automatic test_score_directed();
    int n;
    play_round(100, 190, n);
    vectors++; if (number !== 14'(n) || n != 190) begin errors++; $display("FAIL dir_num0 got %0d exp 190", number); end
    vectors++; if (state !== 3'd3) begin errors++; $display("FAIL dir_state0 got %0d exp 3", state); end
    vectors++; if (total_err !== 18'd90) begin errors++; $display("FAIL dir_total0 got %0d exp 90", total_err); end
    vectors++; if (best_err !== 14'd90) begin errors++; $display("FAIL dir_best0 got %0d exp 90", best_err); end
    vectors++; if (led !== 16'hFFF8) begin errors++; $display("FAIL dir_led0 got %0h exp fff8", led); end
    play_round(100, 120, n);
    vectors++; if (round_idx !== 4'd1) begin errors++; $display("FAIL dir_round1 got %0d exp 1", round_idx); end
    vectors++; if (total_err !== 18'd110) begin errors++; $display("FAIL dir_total1 got %0d exp 110", total_err); end
    vectors++; if (best_err !== 14'd20) begin errors++; $display("FAIL dir_best1 got %0d exp 20", best_err); end
    vectors++; if (led !== 16'hFFFF) begin errors++; $display("FAIL dir_led1 got %0h exp ffff", led); end
    press(1'b0, 1'b0, 1'b1);
    vectors++; if (state !== 3'd4) begin errors++; $display("FAIL dir_done_state got %0d exp 4", state); end
    vectors++; if (done !== 1'b1) begin errors++; $display("FAIL dir_done got %0d exp 1", done); end
    vectors++; if (number !== 14'd110) begin errors++; $display("FAIL dir_done_num got %0d exp 110", number); end
    press(1'b0, 1'b0, 1'b1);
    vectors++; if (state !== 3'd0) begin errors++; $display("FAIL dir_setup got %0d exp 0", state); end
    vectors++; if (total_err !== 18'd0) begin errors++; $display("FAIL dir_clr_total got %0d exp 0", total_err); end
    vectors++; if (best_err !== 14'h3FFF) begin errors++; $display("FAIL dir_clr_best got %0h exp 3fff", best_err); end
    vectors++; if (led !== 16'h0) begin errors++; $display("FAIL dir_clr_led got %0h exp 0", led); end
    vectors++; if (round_idx !== 4'd0) begin errors++; $display("FAIL dir_clr_round got %0d exp 0", round_idx); end
    m_total = 0; m_best = 16383;
  endtask

  task automatic test_target_zero_rate();
    int e;
    press(1'b1, 1'b0, 1'b0); press(1'b1, 1'b0, 1'b0);
    vectors++; if (mode !== 2'd2) begin errors++; $display("FAIL tz_mode got %0d exp 2", mode); end
    rand_in = 14'd0;
    press(1'b0, 1'b0, 1'b1);
    idle(1);
    vectors++; if (number !== 14'd1) begin errors++; $display("FAIL tz_target got %0d exp 1", number); end
    press(1'b0, 1'b0, 1'b1);
    e = last_edge;
    for (int k = 0; k < 10; k++) begin
      step();
      vectors++; if (number !== 14'((cyc - e) / 4)) begin errors++; $display("FAIL tz_rate[%0d] got %0d exp %0d", k, number, (cyc - e) / 4); end
    end
    rst = 1'b0; btn_sel = 1'b1; tick_en = 1'b1;
    step();
    rst = 1'b1; btn_sel = 1'b0; tick_en = 1'b0;
    m_mode = 1; m_total = 0; m_best = 16383;
    vectors++; if (state !== 3'd0) begin errors++; $display("FAIL mid_rst_state got %0d exp 0", state); end
    vectors++; if (mode !== 2'd1) begin errors++; $display("FAIL mid_rst_mode got %0d exp 1", mode); end
    vectors++; if (number !== 14'd0) begin errors++; $display("FAIL mid_rst_number got %0d exp 0", number); end
    vectors++; if (best_err !== 14'h3FFF) begin errors++; $display("FAIL mid_rst_best got %0h exp 3fff", best_err); end
  endtask

  task automatic test_sel_hold();
    for (int i = 0; i < 40; i++) begin
      tick(i == 0, 1'b0, 1'b1);
      idle(1);
    end
    vectors++; if (state !== 3'd1) begin errors++; $display("FAIL hold_state got %0d exp 1", state); end
    vectors++; if (mode !== 2'd1) begin errors++; $display("FAIL hold_mode got %0d exp 1", mode); end
    tick(1'b0, 1'b0, 1'b0);
    do_reset();
  endtask

  task automatic test_saturation();
    int e;
    press(1'b0, 1'b1, 1'b0); model_mode(1'b0, 1'b1);
    rand_in = 14'd5;
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    e = last_edge;
    idle(e + 16382 - cyc);
    vectors++; if (number !== 14'd16382) begin errors++; $display("FAIL sat_pre got %0d exp 16382", number); end
    step();
    vectors++; if (number !== 14'd16383) begin errors++; $display("FAIL sat_max got %0d exp 16383", number); end
    idle(5);
    vectors++; if (number !== 14'd16383) begin errors++; $display("FAIL sat_hold got %0d exp 16383", number); end
    press(1'b0, 1'b0, 1'b1);
    vectors++; if (best_err !== 14'd16378) begin errors++; $display("FAIL sat_best got %0d exp 16378", best_err); end
    vectors++; if (led !== 16'h0) begin errors++; $display("FAIL sat_led got %0h exp 0", led); end
    do_reset();
  endtask

  task automatic test_random_games();
    int n, t, run, tgt, err;
    logic u, d;
    do_reset();
    for (int g = 0; g < 5; g++) begin
      for (int p = 0; p < int'($urandom_range(1, 6)); p++) begin
        u = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1));
        press(u, d, 1'b0);
        model_mode(u, d);
      end
      vectors++; if (mode !== 2'(m_mode)) begin errors++; $display("FAIL rnd_mode[%0d] got %0d exp %0d", g, mode, m_mode); end
      for (int r = 0; r < 2; r++) begin
        t = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 400));
        run = $urandom_range(1, 600);
        play_round(t, run, n);
        tgt = (t == 0) ? 1 : t;
        err = iabs(n - tgt);
        m_total = (m_total + err > 262143) ? 262143 : m_total + err;
        if (err < m_best) m_best = err;
        vectors++; if (number !== 14'(n)) begin errors++; $display("FAIL rnd_num[%0d.%0d] got %0d exp %0d", g, r, number, n); end
        vectors++; if (state !== 3'd3) begin errors++; $display("FAIL rnd_state[%0d.%0d] got %0d exp 3", g, r, state); end
        vectors++; if (round_idx !== 4'(r)) begin errors++; $display("FAIL rnd_round[%0d.%0d] got %0d exp %0d", g, r, round_idx, r); end
        vectors++; if (total_err !== 18'(m_total)) begin errors++; $display("FAIL rnd_total[%0d.%0d] got %0d exp %0d", g, r, total_err, m_total); end
        vectors++; if (best_err !== 14'(m_best)) begin errors++; $display("FAIL rnd_best[%0d.%0d] got %0d exp %0d", g, r, best_err, m_best); end
        vectors++; if (led !== bar_of(err)) begin errors++; $display("FAIL rnd_led[%0d.%0d] got %0h exp %0h", g, r, led, bar_of(err)); end
      end
      press(1'b0, 1'b0, 1'b1);
      vectors++; if (done !== 1'b1) begin errors++; $display("FAIL rnd_done[%0d] got %0d exp 1", g, done); end
      vectors++; if (number !== 14'(m_total)) begin errors++; $display("FAIL rnd_done_num[%0d] got %0d exp %0d", g, number, m_total & 16383); end
      press(1'b0, 1'b0, 1'b1);
      vectors++; if (state !== 3'd0 || total_err !== 18'd0) begin errors++; $display("FAIL rnd_restart[%0d] got state %0d total %0d exp 0 0", g, state, total_err); end
      m_total = 0; m_best = 16383;
    end
  endtask

  initial begin
    rst = 1'b0; tick_en = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0; rand_in = '0;
    test_reset();
    test_mode_select();
    test_score_directed();
    test_target_zero_rate();
    test_sel_hold();
    test_saturation();
    test_random_games();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
